alu_exec_unit: RTL

- Consumer end of the issue-queue-to-executer interface: DISPATCH_WIDTH parallel integer ALU lanes.
- Each lane registers an issued op, computes the ALU result, and presents a registered writeback bundle to the physical register file / ROB side.
- Also provides a same-cycle bypass from the EX stage and a flush, so speculative ops can be squashed in flight.

---
 rtl/alu_exec_unit_pkg.sv | 50 +++++
 rtl/alu_exec_unit_if.sv | 21 ++
 rtl/alu_exec_unit_alu_lane.sv | 33 +++
 rtl/alu_exec_unit.sv | 79 +++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared types and sizing for the integer ALU execution unit.
// Imported by the issue interface, the ALU lane and the top.
package alu_exec_unit_pkg;

   localparam int DISPATCH_WIDTH       = 2;
   localparam int PHYS_REGS_ADDR_WIDTH = 6;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_cmd_t;

   typedef enum logic [0:0] {
      OP_REG = 1'b0,
      OP_IMM = 1'b1
   } op_type_t;

   typedef struct packed {
      logic                            valid;
      logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
      logic [31:0]                     data;
   } wb_t;

   typedef struct packed {
      alu_cmd_t                        cmd;
      logic [31:0]                     op1;
      op_type_t                        op2_type;
      logic [31:0]                     op2;
      logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
   } ex_t;

   function automatic logic [31:0] popcount(
      input logic [DISPATCH_WIDTH-1:0] v
   );
      logic [31:0] n;
      n = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++)
         n = n + 32'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue-queue to executer handshake: one op slot per dispatch lane.
// No backpressure, so only a producer and a consumer view exist.
interface isqIssueIf;
   import alu_exec_unit_pkg::*;

   logic     [DISPATCH_WIDTH-1:0]                           valid;
   alu_cmd_t [DISPATCH_WIDTH-1:0]                           alu_cmd;
   logic     [DISPATCH_WIDTH-1:0][31:0]                     op1;
   op_type_t [DISPATCH_WIDTH-1:0]                           op2_type;
   logic     [DISPATCH_WIDTH-1:0][31:0]                     op2;
   logic     [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;

   modport in (
      input valid, alu_cmd, op1, op2_type, op2, phys_rd
   );

   modport out (
      output valid, alu_cmd, op1, op2_type, op2, phys_rd
   );

endinterface

// File: rtl/alu_exec_unit_alu_lane.sv
// Purely combinational integer ALU for one execution lane.
// Unknown command encodings yield zero.
module alu_lane
   import alu_exec_unit_pkg::*;
(
   input  logic [3:0]  cmd,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic [31:0] result
);

   logic [4:0] sh;

   assign sh = op2[4:0];

   always_comb begin
      result = '0;
      unique case (cmd)
         ALU_ADD:  result = op1 + op2;
         ALU_SUB:  result = op1 - op2;
         ALU_AND:  result = op1 & op2;
         ALU_OR:   result = op1 | op2;
         ALU_XOR:  result = op1 ^ op2;
         ALU_SLL:  result = op1 << sh;
         ALU_SRL:  result = op1 >> sh;
         ALU_SRA:  result = $signed(op1) >>> sh;
         ALU_SLT:  result = {31'b0, $signed(op1) < $signed(op2)};
         ALU_SLTU: result = {31'b0, op1 < op2};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execution unit: per lane EX and WB registers around an ALU,
// an EX-stage bypass, a pipeline-wide flush and a writeback counter.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   isqIssueIf.in               issue,
   input  logic                flush,
   output logic [DISPATCH_WIDTH-1:0]                           byp_valid,
   output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] byp_phys_rd,
   output logic [DISPATCH_WIDTH-1:0][31:0]                     byp_data,
   output logic [DISPATCH_WIDTH-1:0]                           wb_valid,
   output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd,
   output logic [DISPATCH_WIDTH-1:0][31:0]                     wb_data,
   output logic [31:0]                                         exec_count
);

   logic [DISPATCH_WIDTH-1:0] ex_valid;
   ex_t  [DISPATCH_WIDTH-1:0] ex_q;
   wb_t  [DISPATCH_WIDTH-1:0] wb_q;
   logic [31:0]               alu_res [DISPATCH_WIDTH];

   for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_lane
      alu_lane u_alu (
         .cmd    (ex_q[i].cmd),
         .op1    (ex_q[i].op1),
         .op2    (ex_q[i].op2),
         .result (alu_res[i])
      );

      // op2_type is carried only for debug visibility
      always_comb begin
         if (rst_n && ex_valid[i])
            assert (!$isunknown(ex_q[i]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= '0;
         ex_q       <= '0;
         wb_q       <= '0;
         exec_count <= '0;
      end else begin
         exec_count <= exec_count + popcount(wb_valid);
         for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            ex_valid[i]   <= issue.valid[i] & ~flush;
            wb_q[i].valid <= ex_valid[i] & ~flush;
            // payloads only move with a valid op to save toggles
            if (issue.valid[i] && !flush) begin
               ex_q[i] <= '{
                  cmd:      issue.alu_cmd[i],
                  op1:      issue.op1[i],
                  op2_type: issue.op2_type[i],
                  op2:      issue.op2[i],
                  phys_rd:  issue.phys_rd[i]
               };
            end
            if (ex_valid[i]) begin
               wb_q[i].phys_rd <= ex_q[i].phys_rd;
               wb_q[i].data    <= alu_res[i];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         byp_valid[i]   = ex_valid[i];
         byp_phys_rd[i] = ex_q[i].phys_rd;
         byp_data[i]    = alu_res[i];
         wb_valid[i]    = wb_q[i].valid;
         wb_phys_rd[i]  = wb_q[i].phys_rd;
         wb_data[i]     = wb_q[i].data;
      end
   end

endmodule
